int_ctrl: RTL and testbench

Three-level nested priority interrupt controller for the multi-cycle MIPS core. It captures rising edges on external lines `inter1`..`inter3` and holds them pending. It presents the highest-priority pending request to the CPU with its handler vector and tracks the nested in-service levels, exported as `inter_running1..3`. It sits between the board interrupt inputs and the CPU control unit, and replaces ad-hoc interrupt logic inside `top`.

---
 rtl/int_pkg.sv | 27 ++
 rtl/int_edge_det.sv | 26 ++
 rtl/int_ctrl.sv | 135 +++++++++++++
 tb/tb_int_ctrl.sv | 198 +++++++++++++++++++
 4 files changed

// File: rtl/int_pkg.sv
// rtl/int_pkg.sv - shared level encoding, FSM states and default vectors for int_ctrl
package int_pkg;

    localparam logic [1:0] LVL_NONE = 2'd0;
    localparam logic [1:0] LVL1     = 2'd1;
    localparam logic [1:0] LVL2     = 2'd2;
    localparam logic [1:0] LVL3     = 2'd3;

    localparam logic [31:0] VEC1_DEF = 32'h0000_0100;
    localparam logic [31:0] VEC2_DEF = 32'h0000_0200;
    localparam logic [31:0] VEC3_DEF = 32'h0000_0300;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        REQ   = 2'd1,
        ACKED = 2'd2
    } state_t;

    // Highest set bit of a per-level flag vector, bit k-1 = level k.
    function automatic logic [1:0] top_level(input logic [2:0] bits);
        if (bits[2])      return LVL3;
        else if (bits[1]) return LVL2;
        else if (bits[0]) return LVL1;
        else              return LVL_NONE;
    endfunction

endpackage

// File: rtl/int_edge_det.sv
// rtl/int_edge_det.sv - rising-edge capture of one interrupt line into a pending flag
module int_edge_det (
    input  logic clk,
    input  logic clr,
    input  logic line,
    input  logic clear,
    output logic pend
);

    logic prev;

    // A fresh edge in the same cycle as a clear keeps the request pending.
    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            prev <= 1'b0;
            pend <= 1'b0;
        end else begin
            prev <= line;
            if (line && !prev)
                pend <= 1'b1;
            else if (clear)
                pend <= 1'b0;
        end
    end

endmodule

// File: rtl/int_ctrl.sv
// rtl/int_ctrl.sv - three-level nested priority interrupt controller
module int_ctrl
    import int_pkg::*;
#(
    parameter logic [31:0] VEC1 = VEC1_DEF,
    parameter logic [31:0] VEC2 = VEC2_DEF,
    parameter logic [31:0] VEC3 = VEC3_DEF
) (
    input  logic        clk,
    input  logic        clr,
    input  logic        inter1,
    input  logic        inter2,
    input  logic        inter3,
    input  logic        ie,
    input  logic        int_ack,
    input  logic        eret,
    output logic        int_req,
    output logic [31:0] int_vec,
    output logic [1:0]  int_level,
    output logic        inter_running1,
    output logic        inter_running2,
    output logic        inter_running3,
    output logic [2:0]  pending
);

    state_t     state;
    logic [2:0] running;
    logic [2:0] clear_pend;
    logic [1:0] cur;
    logic [1:0] cand;
    logic       want;
    logic       taken;

    function automatic logic [31:0] vec_of(input logic [1:0] lvl);
        case (lvl)
            LVL1:    return VEC1;
            LVL2:    return VEC2;
            LVL3:    return VEC3;
            default: return 32'h0;
        endcase
    endfunction

    assign cur   = top_level(running);
    assign cand  = top_level(pending);
    assign want  = ie && (cand > cur);
    // eret wins over a same-cycle ack, so the ack is dropped entirely.
    assign taken = (state == REQ) && int_ack && !eret;

    assign inter_running1 = running[0];
    assign inter_running2 = running[1];
    assign inter_running3 = running[2];

    always_comb begin
        clear_pend = 3'b000;
        if (taken) begin
            case (cand)
                LVL1:    clear_pend[0] = 1'b1;
                LVL2:    clear_pend[1] = 1'b1;
                LVL3:    clear_pend[2] = 1'b1;
                default: clear_pend    = 3'b000;
            endcase
        end
    end

    int_edge_det u_edge1 (.clk(clk), .clr(clr), .line(inter1), .clear(clear_pend[0]), .pend(pending[0]));
    int_edge_det u_edge2 (.clk(clk), .clr(clr), .line(inter2), .clear(clear_pend[1]), .pend(pending[1]));
    int_edge_det u_edge3 (.clk(clk), .clr(clr), .line(inter3), .clear(clear_pend[2]), .pend(pending[2]));

    // eret retires only the innermost handler level.
    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            running <= 3'b000;
        end else if (eret) begin
            case (cur)
                LVL1:    running[0] <= 1'b0;
                LVL2:    running[1] <= 1'b0;
                LVL3:    running[2] <= 1'b0;
                default: running    <= running;
            endcase
        end else if (taken) begin
            case (cand)
                LVL1:    running[0] <= 1'b1;
                LVL2:    running[1] <= 1'b1;
                LVL3:    running[2] <= 1'b1;
                default: running    <= running;
            endcase
        end
    end

    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            state     <= IDLE;
            int_req   <= 1'b0;
            int_level <= LVL_NONE;
            int_vec   <= 32'h0;
        end else begin
            case (state)
                IDLE: begin
                    if (want) begin
                        state     <= REQ;
                        int_req   <= 1'b1;
                        int_level <= cand;
                        int_vec   <= vec_of(cand);
                    end
                end
                REQ: begin
                    if (int_ack && !eret) begin
                        state     <= ACKED;
                        int_req   <= 1'b0;
                        int_level <= LVL_NONE;
                        int_vec   <= 32'h0;
                    end else if ((int_ack && eret) || !want) begin
                        state     <= IDLE;
                        int_req   <= 1'b0;
                        int_level <= LVL_NONE;
                        int_vec   <= 32'h0;
                    end else begin
                        int_level <= cand;
                        int_vec   <= vec_of(cand);
                    end
                end
                ACKED: begin
                    state <= IDLE;
                end
                default: begin
                    state     <= IDLE;
                    int_req   <= 1'b0;
                    int_level <= LVL_NONE;
                    int_vec   <= 32'h0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_int_ctrl.sv
// tb/tb_int_ctrl.sv - table-driven and randomized checks of int_ctrl against a reference model
module tb_int_ctrl;

    logic        clk;
    logic        clr;
    logic        inter1, inter2, inter3;
    logic        ie, int_ack, eret;
    logic        int_req;
    logic [31:0] int_vec;
    logic [1:0]  int_level;
    logic        inter_running1, inter_running2, inter_running3;
    logic [2:0]  pending;

    int vectors;
    int miscompares;

    int_ctrl dut (
        .clk(clk), .clr(clr),
        .inter1(inter1), .inter2(inter2), .inter3(inter3),
        .ie(ie), .int_ack(int_ack), .eret(eret),
        .int_req(int_req), .int_vec(int_vec), .int_level(int_level),
        .inter_running1(inter_running1), .inter_running2(inter_running2),
        .inter_running3(inter_running3), .pending(pending)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct {
        logic [2:0] line;
        logic       ie;
        logic       ack;
        logic       eret;
        logic       req;
        logic [1:0] lvl;
        logic [2:0] run;
        logic [2:0] pend;
    } row_t;

    row_t tv[$];

    task automatic add(input logic [2:0] line, input logic ie_v, input logic ack, input logic er,
                       input logic req, input logic [1:0] lvl, input logic [2:0] run, input logic [2:0] pend);
        row_t r;
        r.line = line; r.ie = ie_v; r.ack = ack; r.eret = er;
        r.req = req; r.lvl = lvl; r.run = run; r.pend = pend;
        tv.push_back(r);
    endtask

    function automatic logic [31:0] exp_vec(input int lvl);
        case (lvl)
            1:       return 32'h0000_0100;
            2:       return 32'h0000_0200;
            3:       return 32'h0000_0300;
            default: return 32'h0;
        endcase
    endfunction

    task automatic check(input string name, input logic req, input int lvl,
                         input logic [2:0] run, input logic [2:0] pend);
        logic [2:0] act_run;
        act_run = {inter_running3, inter_running2, inter_running1};
        vectors++;
        if (int_req !== req || int_level !== 2'(lvl) || int_vec !== exp_vec(lvl) ||
            act_run !== run || pending !== pend) begin
            miscompares++;
            $display("FAIL %s: got req=%b lvl=%0d vec=%h run=%b pend=%b, want req=%b lvl=%0d vec=%h run=%b pend=%b",
                     name, int_req, int_level, int_vec, act_run, pending,
                     req, lvl, exp_vec(lvl), run, pend);
        end
    endtask

    task automatic drive(input logic [2:0] line, input logic ie_v, input logic ack, input logic er);
        inter1 = line[0]; inter2 = line[1]; inter3 = line[2];
        ie = ie_v; int_ack = ack; eret = er;
    endtask

    // Reference model: levels as integers, flags indexed by level number.
    bit [3:1] m_pend, m_run, m_prev;
    bit       m_req, m_hold;
    int       m_lvl;

    function automatic int highest(input bit [3:1] b);
        int h = 0;
        for (int k = 1; k <= 3; k++) if (b[k]) h = k;
        return h;
    endfunction

    task automatic model_step(input bit [3:1] line, input bit ie_v, input bit ack, input bit er);
        int  cur, cand;
        bit  take;
        bit [3:1] np, nr;
        cur  = highest(m_run);
        cand = highest(m_pend);
        take = m_req && ack && !er;
        nr = m_run;
        if (er && cur > 0)  nr[cur]  = 1'b0;
        else if (take)      nr[cand] = 1'b1;
        for (int k = 1; k <= 3; k++)
            np[k] = (line[k] && !m_prev[k]) || (m_pend[k] && !(take && cand == k));
        if (m_hold || take || (m_req && ack && er)) m_req = 1'b0;
        else                                        m_req = ie_v && (cand > cur);
        m_lvl  = m_req ? cand : 0;
        m_hold = take;
        m_pend = np;
        m_run  = nr;
        m_prev = line;
    endtask

    initial begin
        vectors = 0;
        miscompares = 0;
        clr = 1'b0;
        drive(3'b000, 1'b1, 1'b0, 1'b0);
        #2;
        check("reset_state", 1'b0, 0, 3'b000, 3'b000);

        // line, ie, ack, eret -> req, lvl, run{3,2,1}, pend{3,2,1}
        add(3'b001,1,0,0, 0,0,3'b000,3'b001); add(3'b000,1,0,0, 1,1,3'b000,3'b001);
        add(3'b000,1,1,0, 0,0,3'b001,3'b000); add(3'b000,1,0,0, 0,0,3'b001,3'b000);
        add(3'b100,1,0,0, 0,0,3'b001,3'b100); add(3'b000,1,0,0, 1,3,3'b001,3'b100);
        add(3'b000,1,1,0, 0,0,3'b101,3'b000); add(3'b000,1,0,0, 0,0,3'b101,3'b000);
        add(3'b000,1,0,1, 0,0,3'b001,3'b000); add(3'b000,1,0,1, 0,0,3'b000,3'b000);
        add(3'b000,1,0,0, 0,0,3'b000,3'b000);
        add(3'b100,1,0,0, 0,0,3'b000,3'b100); add(3'b000,1,0,0, 1,3,3'b000,3'b100);
        add(3'b000,1,1,0, 0,0,3'b100,3'b000); add(3'b001,1,0,0, 0,0,3'b100,3'b001);
        add(3'b000,1,0,0, 0,0,3'b100,3'b001); add(3'b000,1,0,1, 0,0,3'b000,3'b001);
        add(3'b000,1,0,0, 1,1,3'b000,3'b001); add(3'b000,1,1,0, 0,0,3'b001,3'b000);
        add(3'b000,1,0,1, 0,0,3'b000,3'b000); add(3'b000,1,0,0, 0,0,3'b000,3'b000);
        add(3'b101,1,0,0, 0,0,3'b000,3'b101); add(3'b000,1,0,0, 1,3,3'b000,3'b101);
        add(3'b000,1,1,0, 0,0,3'b100,3'b001); add(3'b000,1,0,0, 0,0,3'b100,3'b001);
        add(3'b000,1,0,0, 0,0,3'b100,3'b001); add(3'b000,1,0,1, 0,0,3'b000,3'b001);
        add(3'b000,1,0,0, 1,1,3'b000,3'b001);
        add(3'b010,1,0,0, 1,1,3'b000,3'b011); add(3'b000,1,0,0, 1,2,3'b000,3'b011);
        add(3'b000,1,1,0, 0,0,3'b010,3'b001); add(3'b000,1,0,0, 0,0,3'b010,3'b001);
        add(3'b000,1,0,1, 0,0,3'b000,3'b001); add(3'b000,1,0,0, 1,1,3'b000,3'b001);
        add(3'b000,1,1,0, 0,0,3'b001,3'b000); add(3'b000,1,0,1, 0,0,3'b000,3'b000);
        add(3'b010,0,0,0, 0,0,3'b000,3'b010); add(3'b000,0,0,0, 0,0,3'b000,3'b010);
        add(3'b000,1,0,0, 1,2,3'b000,3'b010); add(3'b000,1,1,0, 0,0,3'b010,3'b000);
        add(3'b000,1,0,1, 0,0,3'b000,3'b000); add(3'b000,1,1,0, 0,0,3'b000,3'b000);
        add(3'b001,1,0,0, 0,0,3'b000,3'b001); add(3'b001,1,0,0, 1,1,3'b000,3'b001);
        add(3'b001,1,1,0, 0,0,3'b001,3'b000); add(3'b001,1,0,0, 0,0,3'b001,3'b000);
        add(3'b000,1,0,1, 0,0,3'b000,3'b000);
        add(3'b010,1,0,0, 0,0,3'b000,3'b010); add(3'b000,1,0,0, 1,2,3'b000,3'b010);
        add(3'b000,1,1,1, 0,0,3'b000,3'b010); add(3'b000,1,0,0, 1,2,3'b000,3'b010);
        add(3'b000,1,1,0, 0,0,3'b010,3'b000); add(3'b000,1,0,1, 0,0,3'b000,3'b000);
        add(3'b010,1,0,0, 0,0,3'b000,3'b010); add(3'b000,1,0,0, 1,2,3'b000,3'b010);
        add(3'b010,1,1,0, 0,0,3'b010,3'b010); add(3'b000,1,0,0, 0,0,3'b010,3'b010);
        add(3'b000,1,0,0, 0,0,3'b010,3'b010); add(3'b000,1,0,1, 0,0,3'b000,3'b010);
        add(3'b000,1,0,0, 1,2,3'b000,3'b010); add(3'b000,1,1,0, 0,0,3'b010,3'b000);
        add(3'b000,1,0,1, 0,0,3'b000,3'b000);
        add(3'b010,1,0,0, 0,0,3'b000,3'b010); add(3'b000,1,0,0, 1,2,3'b000,3'b010);
        add(3'b000,1,1,0, 0,0,3'b010,3'b000); add(3'b100,1,0,0, 0,0,3'b010,3'b100);
        add(3'b000,1,0,0, 1,3,3'b010,3'b100); add(3'b000,1,1,0, 0,0,3'b110,3'b000);
        add(3'b001,1,0,0, 0,0,3'b110,3'b001);

        @(negedge clk);
        clr = 1'b1;
        for (int i = 0; i < tv.size(); i++) begin
            drive(tv[i].line, tv[i].ie, tv[i].ack, tv[i].eret);
            @(negedge clk);
            check($sformatf("row%0d", i), tv[i].req, int'(tv[i].lvl), tv[i].run, tv[i].pend);
        end

        // Asynchronous reset in mid-service, observed before any clock edge.
        drive(3'b000, 1'b1, 1'b0, 1'b0);
        #2 clr = 1'b0;
        #1 check("async_reset", 1'b0, 0, 3'b000, 3'b000);
        @(negedge clk);
        check("reset_held", 1'b0, 0, 3'b000, 3'b000);

        m_pend = '0; m_run = '0; m_prev = '0; m_req = 1'b0; m_hold = 1'b0; m_lvl = 0;
        clr = 1'b1;
        begin
            bit [3:1] line;
            bit       ie_r, ack, er;
            line = '0;
            ie_r = 1'b1;
            for (int c = 0; c < 3000; c++) begin
                for (int k = 1; k <= 3; k++)
                    if ($urandom_range(0, 7) == 0) line[k] = ~line[k];
                if ($urandom_range(0, 15) == 0) ie_r = ~ie_r;
                ack = ie_r && ($urandom_range(0, 2) == 0);
                er  = ($urandom_range(0, 11) == 0);
                drive({line[3], line[2], line[1]}, ie_r, ack, er);
                model_step(line, ie_r, ack, er);
                @(negedge clk);
                check($sformatf("rand%0d", c), m_req, m_lvl, 3'(m_run), 3'(m_pend));
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
